// File: rtl/disp_pkg.sv
// Shared types and helpers for the 4-digit display scan path.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    GUARD = 2'd2
  } scan_state_t;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SEL_W      = 2;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

  // Active-low anode pattern with only the selected digit driven low.
  function automatic logic [NUM_DIGITS-1:0] onehot_low(input logic [SEL_W-1:0] sel);
    logic [NUM_DIGITS-1:0] an;
    an      = AN_OFF;
    an[sel] = 1'b0;
    return an;
  endfunction

endpackage

// File: rtl/digit_scan_ctrl_scan_slot_counter.sv
// Slot counter shared by the SHOW and GUARD phases: synchronous clear,
// increment, and terminal-count compare against a loadable limit.
module scan_slot_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt_nxt_c,
  output logic         tc_c
);

  logic [W-1:0] cnt;

  always_comb begin
    cnt_nxt_c = cnt;
    if (clr) begin
      cnt_nxt_c = '0;
    end else if (inc) begin
      cnt_nxt_c = cnt + W'(1);
    end
  end

  assign tc_c = (cnt == term);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt_c;
    end
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Digit scan sequencer: walks SEL/AN through 4 digits with a blanking gap.
// Optional brightness windowing is compiled in with `define DIMMING_EN.
module digit_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned PRESCALE    = 50000,
  parameter int unsigned DEAD_CYCLES = 16,
  parameter int unsigned CNT_W       = $clog2(PRESCALE)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  EN,
  input  logic [NUM_DIGITS-1:0] BLANK_MASK,
  input  logic [2:0]            BRIGHT,
  output logic [SEL_W-1:0]      SEL,
  output logic [NUM_DIGITS-1:0] AN,
  output logic                  SCAN_TICK
);

  // Counter is wide enough for whichever phase is longer.
  localparam int unsigned DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam int unsigned SLOT_W = (CNT_W > DEAD_W) ? CNT_W : DEAD_W;
  localparam logic [SLOT_W-1:0] SHOW_LAST  = SLOT_W'(PRESCALE - 1);
  localparam logic [SLOT_W-1:0] GUARD_LAST =
    SLOT_W'(((DEAD_CYCLES > 0) ? DEAD_CYCLES : 1) - 1);
  localparam logic HAS_GUARD = (DEAD_CYCLES > 0);

  scan_state_t           state_q;
  scan_state_t           state_nxt;
  logic [SLOT_W-1:0]     cnt_nxt;
  logic [SLOT_W-1:0]     term;
  logic                  tc;
  logic                  cnt_clr;
  logic                  lit_c;
  logic [SEL_W-1:0]      sel_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic                  tick_nxt;

  assign term    = (state_q == GUARD) ? GUARD_LAST : SHOW_LAST;
  assign cnt_clr = (state_q == IDLE) || !EN || tc;

  scan_slot_counter #(
    .W (SLOT_W)
  ) u_slot_cnt (
    .clk       (CLK),
    .rst_n     (RST_N),
    .clr       (cnt_clr),
    .inc       (1'b1),
    .term      (term),
    .cnt_nxt_c (cnt_nxt),
    .tc_c      (tc)
  );

`ifdef DIMMING_EN
  // Lit window is the first ((BRIGHT+1)*PRESCALE)/8 counts of the slot.
  localparam int unsigned LIM_W = CNT_W + 4;
  localparam int unsigned CMP_W = (LIM_W > SLOT_W) ? LIM_W : SLOT_W;
  logic [LIM_W-1:0] on_limit;
  assign on_limit = ((LIM_W'(BRIGHT) + LIM_W'(1)) * LIM_W'(PRESCALE)) >> 3;
  assign lit_c    = CMP_W'(cnt_nxt) < CMP_W'(on_limit);
`else
  logic unused_dim;
  assign unused_dim = ^{BRIGHT, cnt_nxt};
  assign lit_c      = 1'b1;
`endif

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic; EN low always wins over a slot end
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (EN) state_nxt = SHOW;
      SHOW: begin
        if (!EN)                  state_nxt = IDLE;
        else if (tc && HAS_GUARD) state_nxt = GUARD;
      end
      GUARD: begin
        if (!EN)     state_nxt = IDLE;
        else if (tc) state_nxt = SHOW;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next output values, registered below alongside the state
  always_comb begin
    sel_nxt  = SEL;
    tick_nxt = 1'b0;
    an_nxt   = AN_OFF;
    if (state_q == IDLE && EN) begin
      sel_nxt = '0;
    end else if (EN && tc && (state_q == GUARD || (state_q == SHOW && !HAS_GUARD))) begin
      sel_nxt  = SEL + SEL_W'(1);
      tick_nxt = 1'b1;
    end
    if (state_nxt == SHOW && lit_c && !BLANK_MASK[sel_nxt]) begin
      an_nxt = onehot_low(sel_nxt);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      SEL       <= '0;
      AN        <= AN_OFF;
      SCAN_TICK <= 1'b0;
    end else begin
      SEL       <= sel_nxt;
      AN        <= an_nxt;
      SCAN_TICK <= tick_nxt;
    end
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Bench for digit_scan_ctrl: three configurations against a position-based
// model of the scan (digit = pos / slot_len, phase = pos % slot_len).
module tb_digit_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] mask;
  logic [2:0] bright;

  logic [1:0] sel_o  [3];
  logic [3:0] an_o   [3];
  logic       tick_o [3];

  int tests = 0;
  int fails = 0;

  // DUT 0: P=4 D=2, DUT 1: P=4 D=0, DUT 2: P=8 D=3
  digit_scan_ctrl #(.PRESCALE(4), .DEAD_CYCLES(2)) u_dut0 (
    .CLK(clk), .RST_N(rst_n), .EN(en), .BLANK_MASK(mask), .BRIGHT(bright),
    .SEL(sel_o[0]), .AN(an_o[0]), .SCAN_TICK(tick_o[0]));
  digit_scan_ctrl #(.PRESCALE(4), .DEAD_CYCLES(0)) u_dut1 (
    .CLK(clk), .RST_N(rst_n), .EN(en), .BLANK_MASK(mask), .BRIGHT(bright),
    .SEL(sel_o[1]), .AN(an_o[1]), .SCAN_TICK(tick_o[1]));
  digit_scan_ctrl #(.PRESCALE(8), .DEAD_CYCLES(3)) u_dut2 (
    .CLK(clk), .RST_N(rst_n), .EN(en), .BLANK_MASK(mask), .BRIGHT(bright),
    .SEL(sel_o[2]), .AN(an_o[2]), .SCAN_TICK(tick_o[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int ps(int k);
    return (k == 2) ? 8 : 4;
  endfunction

  function automatic int ds(int k);
    return (k == 0) ? 2 : ((k == 1) ? 0 : 3);
  endfunction

  function automatic logic [1:0] m_sel(int k, int p);
    return 2'((p / (ps(k) + ds(k))) % 4);
  endfunction

  function automatic logic m_tick(int k, int p);
    return (p != 0) && ((p % (ps(k) + ds(k))) == 0);
  endfunction

  function automatic logic [3:0] m_an(int k, int p, logic [3:0] m, logic [2:0] b);
    int off;
    int lim;
    int s;
    logic [3:0] v;
    s   = (p / (ps(k) + ds(k))) % 4;
    off = p % (ps(k) + ds(k));
`ifdef DIMMING_EN
    lim = ((int'(b) + 1) * ps(k)) >> 3;
`else
    lim = ps(k) + 0 * int'(b);
`endif
    v = 4'hF;
    if (off < ps(k) && off < lim && !m[s]) v[s] = 1'b0;
    return v;
  endfunction

  function automatic int npos(logic a, int p);
    return a ? p + 1 : 0;
  endfunction

  // Reference model: position since the last scan entry
  logic       act   [3];
  int         pos   [3];
  logic [1:0] e_sel [3];
  logic [3:0] e_an  [3];
  logic       e_tick[3];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        act[k]    <= 1'b0;
        pos[k]    <= 0;
        e_sel[k]  <= 2'd0;
        e_an[k]   <= 4'hF;
        e_tick[k] <= 1'b0;
      end else if (!en) begin
        act[k]    <= 1'b0;
        e_an[k]   <= 4'hF;
        e_tick[k] <= 1'b0;
      end else begin
        act[k]    <= 1'b1;
        pos[k]    <= npos(act[k], pos[k]);
        e_sel[k]  <= m_sel(k, npos(act[k], pos[k]));
        e_an[k]   <= m_an(k, npos(act[k], pos[k]), mask, bright);
        e_tick[k] <= m_tick(k, npos(act[k], pos[k]));
      end
    end
  end

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  // Per-cycle compare against the model
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("sel[%0d]", k), 32'(sel_o[k]), 32'(e_sel[k]));
      chk($sformatf("an[%0d]", k), 32'(an_o[k]), 32'(e_an[k]));
      chk($sformatf("tick[%0d]", k), 32'(tick_o[k]), 32'(e_tick[k]));
    end
  end

  task automatic restart();
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
  endtask

  // Lit cycles of DUT 2 over one full scan period from entry
  task automatic measure_lit(input logic [2:0] b, output int n);
    bright = b;
    restart();
    n = 0;
    for (int i = 0; i < 44; i++) begin
      if (an_o[2] != 4'hF) n++;
      @(negedge clk);
    end
  endtask

  int n_tick0, n_tick1, n_bad, n_sel3, n_lit;

  initial begin
    rst_n  = 1'b0;
    en     = 1'b0;
    mask   = 4'h0;
    bright = 3'd7;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_an", 32'(an_o[0]), 32'hF);
    chk("rst_sel", 32'(sel_o[0]), 32'h0);
    chk("rst_tick", 32'(tick_o[0]), 32'h0);

    en = 1'b1;
    @(negedge clk);
    chk("entry_an", 32'(an_o[0]), 32'hE);
    chk("entry_tick", 32'(tick_o[0]), 32'h0);
    repeat (3) @(negedge clk);
    chk("d0_last_an", 32'(an_o[1]), 32'hE);
    @(negedge clk);
    chk("d0_next_an", 32'(an_o[1]), 32'hD);
    chk("d0_next_tick", 32'(tick_o[1]), 32'h1);
    chk("guard_an", 32'(an_o[0]), 32'hF);
    repeat (5) @(negedge clk);
    chk("pre_drop_an", 32'(an_o[0]), 32'hD);
    en = 1'b0;
    @(negedge clk);
    chk("drop_an", 32'(an_o[0]), 32'hF);
    chk("drop_sel", 32'(sel_o[0]), 32'h1);
    chk("drop_tick", 32'(tick_o[0]), 32'h0);
    en = 1'b1;
    @(negedge clk);
    chk("reentry_sel", 32'(sel_o[0]), 32'h0);
    chk("reentry_an", 32'(an_o[0]), 32'hE);

    n_tick0 = 0;
    n_tick1 = 0;
    repeat (48) begin
      @(negedge clk);
      n_tick0 += int'(tick_o[0]);
      n_tick1 += int'(tick_o[1]);
    end
    chk("ticks_d2_48", 32'(n_tick0), 32'd8);
    chk("ticks_d0_48", 32'(n_tick1), 32'd12);

    mask    = 4'b1000;
    n_tick0 = 0;
    n_bad   = 0;
    n_sel3  = 0;
    repeat (48) begin
      @(negedge clk);
      n_tick0 += int'(tick_o[0]);
      if (an_o[0] == 4'b0111) n_bad++;
      if (sel_o[0] == 2'd3) n_sel3++;
    end
    chk("mask_ticks", 32'(n_tick0), 32'd8);
    chk("mask_an0111", 32'(n_bad), 32'd0);
    chk("mask_sel3_seen", 32'(n_sel3 > 0), 32'd1);
    mask = 4'h0;

    measure_lit(3'd3, n_lit);
`ifdef DIMMING_EN
    chk("lit_b3", 32'(n_lit), 32'd16);
`else
    chk("lit_b3", 32'(n_lit), 32'd32);
`endif
    measure_lit(3'd7, n_lit);
    chk("lit_b7", 32'(n_lit), 32'd32);
    measure_lit(3'd0, n_lit);
`ifdef DIMMING_EN
    chk("lit_b0", 32'(n_lit), 32'd4);
`else
    chk("lit_b0", 32'(n_lit), 32'd32);
`endif
    bright = 3'd7;

    // Async reset while DUT 0 sits in the guard gap after digit 2
    restart();
    repeat (16) @(negedge clk);
    chk("pre_rst_sel", 32'(sel_o[0]), 32'h2);
    chk("pre_rst_an", 32'(an_o[0]), 32'hF);
    #2 rst_n = 1'b0;
    #1;
    chk("async_sel", 32'(sel_o[0]), 32'h0);
    chk("async_an", 32'(an_o[0]), 32'hF);
    chk("async_tick", 32'(tick_o[0]), 32'h0);
    chk("async_sel2", 32'(sel_o[2]), 32'h0);
    @(negedge clk);
    en    = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_an", 32'(an_o[0]), 32'hF);
    chk("post_rst_sel", 32'(sel_o[0]), 32'h0);

    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 99) >= 4);
      if ($urandom_range(0, 15) == 0) mask = 4'($urandom);
      if ($urandom_range(0, 31) == 0) bright = 3'($urandom);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
